// File: rtl/arb_mux_pkg.sv
// Shared types and helpers for the arbitrating mux.
// Arbitration modes, channel-index width and one-hot decode.
package arb_mux_pkg;

  typedef enum logic {
    ARB_FIXED,
    ARB_RR
  } arb_mode_e;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int onehot_to_idx(
    input logic [31:0] oh
  );
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++)
      if (oh[i]) idx = i;
    return idx;
  endfunction

endpackage

// File: rtl/arb_mux_reg_pick.sv
// Combinational priority pick starting at a rotating pointer.
// Produces a one-hot grant, its index and an any-request flag.
module arb_pick
  import arb_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [CH_W-1:0]   idx_o,
  output logic              any_o
);

  logic found;
  int   k;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      k = (int'(ptr_i) + i) % NUM_CH;
      if (!found && req_i[k]) begin
        gnt_o[k] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign any_o = |req_i;
  assign idx_o = CH_W'(onehot_to_idx(32'(gnt_o)));

endmodule

// File: rtl/arb_mux_reg.sv
// N-channel arbitrating mux with a registered valid/ready output.
// Fixed-priority or round-robin selection, one beat per cycle.
module arb_mux_reg
  import arb_mux_pkg::*;
#(
  parameter int        NUM_CH = 4,
  parameter int        DATA_W = 8,
  parameter arb_mode_e MODE   = ARB_RR,
  localparam int       CH_W   = ch_w(NUM_CH)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_CH-1:0]        req_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] req_data_i,
  output logic [NUM_CH-1:0]        req_ready_o,
  output logic                     out_valid_o,
  output logic [DATA_W-1:0]        out_data_o,
  output logic [CH_W-1:0]          out_ch_o,
  output logic [NUM_CH-1:0]        out_grant_o,
  input  logic                     out_ready_i
);

  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [CH_W-1:0]   pick_ptr, pick_idx;
  logic [NUM_CH-1:0] pick_gnt;
  logic              pick_any, load, accept;

  assign pick_ptr = (MODE == ARB_RR) ? ptr_q : '0;

  arb_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_pick (
    .req_i  (req_valid_i),
    .ptr_i  (pick_ptr),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign load   = ~valid_q | out_ready_i;
  // Gate with reset so nothing is handshaken while held in reset.
  assign accept = load & pick_any & ~rst_i;
  assign req_ready_o = accept ? pick_gnt : '0;

  always_comb begin
    ptr_d   = ptr_q;
    ch_d    = ch_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      valid_d = pick_any;
      if (pick_any) begin
        ch_d   = pick_idx;
        data_d = req_data_i[int'(pick_idx)*DATA_W +: DATA_W];
        ptr_d  = (pick_idx == CH_W'(NUM_CH-1))
               ? '0 : pick_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q   <= '0;
      ch_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_ch_o    = ch_q;
  assign out_grant_o = valid_q
                     ? (NUM_CH'(1) << ch_q) : '0;

endmodule

// File: tb/tb_arb_mux_reg.sv
// Directed bench for arb_mux_reg in round-robin and fixed modes.
// Both instances share inputs; each task checks one scenario.
module tb_arb_mux_reg;
  import arb_mux_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  valid;
  logic [7:0]  dat [4];
  logic [31:0] data;
  logic        ordy;

  logic [3:0] rr_rdy, rr_g, fx_rdy, fx_g;
  logic       rr_v, fx_v;
  logic [7:0] rr_d, fx_d;
  logic [1:0] rr_ch, fx_ch;

  int checks = 0;
  int errors = 0;

  assign data = {dat[3], dat[2], dat[1], dat[0]};

  always #5 clk = ~clk;

  arb_mux_reg #(.NUM_CH(4), .DATA_W(8), .MODE(ARB_RR)) u_rr (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(valid), .req_data_i(data),
    .req_ready_o(rr_rdy), .out_valid_o(rr_v),
    .out_data_o(rr_d), .out_ch_o(rr_ch),
    .out_grant_o(rr_g), .out_ready_i(ordy)
  );

  arb_mux_reg #(.NUM_CH(4), .DATA_W(8), .MODE(ARB_FIXED)) u_fx (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(valid), .req_data_i(data),
    .req_ready_o(fx_rdy), .out_valid_o(fx_v),
    .out_data_o(fx_d), .out_ch_o(fx_ch),
    .out_grant_o(fx_g), .out_ready_i(ordy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = '0; ordy = 1'b1;
    dat[0] = 8'h11; dat[1] = 8'h22;
    dat[2] = 8'h33; dat[3] = 8'h44;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 4'b1111; ordy = 1'b1;
    dat[0] = 8'h11; dat[1] = 8'h22;
    dat[2] = 8'h33; dat[3] = 8'h44;
    #1;
    checks++;
    if (rr_v !== 1'b0) begin errors++;
      $display("FAIL rst_valid got %b exp 0", rr_v); end
    checks++;
    if (rr_d !== 8'h00) begin errors++;
      $display("FAIL rst_data got %h exp 00", rr_d); end
    checks++;
    if (rr_ch !== 2'd0) begin errors++;
      $display("FAIL rst_ch got %0d exp 0", rr_ch); end
    checks++;
    if (rr_g !== 4'b0000) begin errors++;
      $display("FAIL rst_grant got %b exp 0000", rr_g); end
    checks++;
    if (rr_rdy !== 4'b0000) begin errors++;
      $display("FAIL rst_ready got %b exp 0000", rr_rdy); end
    step();
    checks++;
    if (rr_v !== 1'b0 || fx_v !== 1'b0) begin errors++;
      $display("FAIL rst_hold got %b/%b exp 0/0", rr_v, fx_v); end
    rst = 1'b0;
  endtask

  task automatic test_rr_fair();
    logic [3:0] oh;
    int e;
    valid = 4'b1111; ordy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      e  = i % 4;
      oh = 4'b0001 << e;
      #1;
      checks++;
      if (rr_rdy !== oh) begin errors++;
        $display("FAIL rr_ready c%0d got %b exp %b", i, rr_rdy, oh); end
      checks++;
      if (fx_rdy !== 4'b0001) begin errors++;
        $display("FAIL fx_ready c%0d got %b exp 0001", i, fx_rdy); end
      step();
      checks++;
      if (rr_v !== 1'b1 || rr_ch !== 2'(e)) begin errors++;
        $display("FAIL rr_ch c%0d got %0d v%b exp %0d", i, rr_ch, rr_v, e); end
      checks++;
      if (rr_d !== dat[e]) begin errors++;
        $display("FAIL rr_data c%0d got %h exp %h", i, rr_d, dat[e]); end
      checks++;
      if (rr_g !== oh) begin errors++;
        $display("FAIL rr_grant c%0d got %b exp %b", i, rr_g, oh); end
      checks++;
      if (fx_ch !== 2'd0) begin errors++;
        $display("FAIL fx_ch c%0d got %0d exp 0", i, fx_ch); end
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    #1;
    checks++;
    if (rr_v !== 1'b0 || rr_d !== 8'h00) begin errors++;
      $display("FAIL mid_rst got v%b d%h exp v0 d00", rr_v, rr_d); end
    checks++;
    if (rr_g !== 4'b0000 || rr_ch !== 2'd0) begin errors++;
      $display("FAIL mid_rst_g got %b ch%0d exp 0000 ch0", rr_g, rr_ch); end
    checks++;
    if (rr_rdy !== 4'b0000) begin errors++;
      $display("FAIL mid_rst_rdy got %b exp 0000", rr_rdy); end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (rr_rdy !== 4'b0001) begin errors++;
      $display("FAIL mid_ptr got %b exp 0001", rr_rdy); end
    step();
    checks++;
    if (rr_ch !== 2'd0 || rr_v !== 1'b1) begin errors++;
      $display("FAIL mid_ch got %0d v%b exp 0 v1", rr_ch, rr_v); end
  endtask

  task automatic test_fixed();
    do_reset();
    valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (fx_rdy !== 4'b0010) begin errors++;
        $display("FAIL fx_fix_rdy c%0d got %b exp 0010", i, fx_rdy); end
      step();
      checks++;
      if (fx_ch !== 2'd1 || fx_d !== 8'h22) begin errors++;
        $display("FAIL fx_fix c%0d got ch%0d d%h exp ch1 d22", i, fx_ch, fx_d); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    dat[0] = 8'hA5;
    valid  = 4'b0001;
    step();
    checks++;
    if (rr_d !== 8'hA5 || rr_v !== 1'b1) begin errors++;
      $display("FAIL bp_load got d%h v%b exp dA5 v1", rr_d, rr_v); end
    ordy  = 1'b0;
    valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (rr_rdy !== 4'b0000) begin errors++;
        $display("FAIL bp_rdy c%0d got %b exp 0000", i, rr_rdy); end
      step();
      checks++;
      if (rr_d !== 8'hA5 || rr_ch !== 2'd0) begin errors++;
        $display("FAIL bp_hold c%0d got d%h ch%0d exp dA5 ch0", i, rr_d, rr_ch); end
      checks++;
      if (rr_g !== 4'b0001 || rr_v !== 1'b1) begin errors++;
        $display("FAIL bp_grant c%0d got %b v%b exp 0001 v1", i, rr_g, rr_v); end
    end
    ordy = 1'b1;
    #1;
    checks++;
    if (rr_rdy !== 4'b0010) begin errors++;
      $display("FAIL bp_ptr got %b exp 0010", rr_rdy); end
    step();
    checks++;
    if (rr_ch !== 2'd1 || rr_d !== 8'h22) begin errors++;
      $display("FAIL bp_next got ch%0d d%h exp ch1 d22", rr_ch, rr_d); end
  endtask

  task automatic test_sparse_wrap();
    int exp_ch [3] = '{0, 2, 0};
    do_reset();
    valid = 4'b0100;
    step();
    valid = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (rr_rdy !== (4'b0001 << exp_ch[i])) begin errors++;
        $display("FAIL wrap_rdy c%0d got %b exp ch%0d", i, rr_rdy, exp_ch[i]); end
      step();
      checks++;
      if (rr_ch !== 2'(exp_ch[i])) begin errors++;
        $display("FAIL wrap_ch c%0d got %0d exp %0d", i, rr_ch, exp_ch[i]); end
    end
  endtask

  task automatic test_idle_gap();
    do_reset();
    dat[2] = 8'h3C;
    valid  = 4'b0100;
    step();
    valid = 4'b0000;
    checks++;
    if (rr_v !== 1'b1 || rr_d !== 8'h3C) begin errors++;
      $display("FAIL idle_beat got v%b d%h exp v1 d3C", rr_v, rr_d); end
    checks++;
    if (rr_g !== 4'b0100 || rr_ch !== 2'd2) begin errors++;
      $display("FAIL idle_grant got %b ch%0d exp 0100 ch2", rr_g, rr_ch); end
    step();
    checks++;
    if (rr_v !== 1'b0 || rr_g !== 4'b0000) begin errors++;
      $display("FAIL idle_off got v%b g%b exp v0 g0000", rr_v, rr_g); end
    checks++;
    if (rr_d !== 8'h3C || rr_ch !== 2'd2) begin errors++;
      $display("FAIL idle_hold got d%h ch%0d exp d3C ch2", rr_d, rr_ch); end
    step();
    checks++;
    if (rr_v !== 1'b0 || rr_rdy !== 4'b0000) begin errors++;
      $display("FAIL idle_stay got v%b r%b exp v0 r0000", rr_v, rr_rdy); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rr_fair();
    test_reset_mid();
    test_fixed();
    test_backpressure();
    test_sparse_wrap();
    test_idle_gap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
